// File: rtl/pipe_stage_ctrl.sv
// Pipeline register chain with stall, flush and counted bubble insertion ahead of a parked entry.
// state | meaning: IDLE = pass-through, BUB = issuing bubbles, held entry released when counter hits 0
module pipe_stage_ctrl #(
  parameter int                 WIDTH  = 32,
  parameter int                 DEPTH  = 1,
  parameter int                 CNT_W  = 2,
  parameter logic [WIDTH-1:0]   BUBBLE = {WIDTH{1'b0}}
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             bub_req_i,
  input  logic [CNT_W-1:0] bub_cnt_i,
  output logic             accept_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] bub_left_o
);

  typedef enum logic {IDLE = 1'b0, BUB = 1'b1} state_t;

  state_t                       state_q;
  logic [DEPTH-1:0]             vld_q;
  logic [DEPTH-1:0][WIDTH-1:0]  dat_q;
  logic [WIDTH-1:0]             hold_q;
  logic [CNT_W-1:0]             cnt_q;
  logic                         adv;

  assign adv      = ~stall_i & ~flush_i;
  // reset term keeps upstream from advancing while the chain is held in reset
  assign accept_o = adv & (state_q == IDLE) & valid_i & ~rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q   <= '0;
      for (int k = 0; k < DEPTH; k++) dat_q[k] <= BUBBLE;
      hold_q  <= BUBBLE;
      cnt_q   <= '0;
      state_q <= IDLE;
    end else if (flush_i) begin
      vld_q   <= '0;
      for (int k = 0; k < DEPTH; k++) dat_q[k] <= BUBBLE;
      hold_q  <= BUBBLE;
      cnt_q   <= '0;
      state_q <= IDLE;
    end else if (!stall_i) begin
      for (int k = 1; k < DEPTH; k++) begin
        vld_q[k] <= vld_q[k-1];
        dat_q[k] <= dat_q[k-1];
      end
      case (state_q)
        IDLE: begin
          if (valid_i && bub_req_i && (bub_cnt_i != '0)) begin
            hold_q   <= data_i;
            vld_q[0] <= 1'b0;
            dat_q[0] <= BUBBLE;
            cnt_q    <= bub_cnt_i - CNT_W'(1);
            state_q  <= BUB;
          end else if (valid_i) begin
            vld_q[0] <= 1'b1;
            dat_q[0] <= data_i;
          end else begin
            vld_q[0] <= 1'b0;
            dat_q[0] <= BUBBLE;
          end
        end
        BUB: begin
          if (cnt_q != '0) begin
            vld_q[0] <= 1'b0;
            dat_q[0] <= BUBBLE;
            cnt_q    <= cnt_q - CNT_W'(1);
          end else begin
            vld_q[0] <= 1'b1;
            dat_q[0] <= hold_q;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign valid_o    = vld_q[DEPTH-1];
  assign data_o     = dat_q[DEPTH-1];
  assign busy_o     = (state_q == BUB);
  assign bub_left_o = busy_o ? cnt_q : '0;

endmodule

// File: doc/pipe_stage_ctrl.md
Name: pipe_stage_ctrl

Overview:
- Parametrised pipeline register chain for the CPU datapath: DEPTH stages of {valid, WIDTH-bit payload}.
- Supports stall (hold), flush (kill all in-flight entries) and counted bubble insertion.
- In bubble insertion the incoming instruction is parked and re-issued after N bubbles. This is the general form of the fixed 2-cycle hazard stall used between IF/ID and ID/EX.
- Hazard-detection logic sits upstream and drives bub_req_i/bub_cnt_i.

Parameters:
WIDTH, 32, payload width in bits (>=1)
DEPTH, 1, number of register stages (1..8)
CNT_W, 2, width of bubble count; max bubbles = 2^CNT_W-1
BUBBLE, {WIDTH{1'b0}}, payload value loaded into a stage carrying a bubble or after reset/flush

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  reset, asynchronous, active-high
valid_i  in  1  upstream entry present
data_i  in  WIDTH  upstream payload
stall_i  in  1  hold every stage, FSM and counter this cycle
flush_i  in  1  invalidate all stages and abort bubble sequence
bub_req_i  in  1  insert bubbles ahead of current valid_i entry
bub_cnt_i  in  CNT_W  number of bubbles to insert
accept_o  out  1  current valid_i/data_i consumed this cycle
valid_o  out  1  last-stage valid
data_o  out  WIDTH  last-stage payload
busy_o  out  1  FSM in BUBBLE state
bub_left_o  out  CNT_W  remaining bubbles before held entry is released

Behaviour:
- Reset (async, rst_i=1):
  - All stage valids 0, all stage payloads BUBBLE.
  - Hold register BUBBLE, FSM IDLE, counter 0.
  - Outputs: valid_o=0, data_o=BUBBLE, busy_o=0, bub_left_o=0, accept_o=0.
- adv = ~stall_i & ~flush_i. When adv=1, stage k+1 <= stage k and stage 0 <= selected input.
- Priority: flush_i > stall_i > normal.
- flush_i=1 (regardless of stall_i):
  - Next edge: all valids 0, payloads BUBBLE, hold register cleared, FSM IDLE, counter 0.
  - accept_o=0.
- stall_i=1, flush_i=0: all registers, FSM and counter unchanged; accept_o=0.
- accept_o = adv & (state==IDLE) & valid_i (combinational).
- FSM IDLE, adv=1:
  - valid_i=0: stage 0 <= {0, BUBBLE}.
  - valid_i=1, and bub_req_i=0 or bub_cnt_i==0: stage 0 <= {1, data_i}.
  - valid_i=1, bub_req_i=1, bub_cnt_i=N>0:
    - Hold <= data_i, stage 0 <= {0, BUBBLE}, counter <= N-1, go BUBBLE.
    - Upstream sees accept_o=1, so it advances.
- FSM BUBBLE, adv=1:
  - Inputs are ignored; accept_o=0.
  - counter>0: stage 0 <= {0, BUBBLE}, counter decrements.
  - counter==0: stage 0 <= {1, hold}, go IDLE.
  - Result: exactly N bubbles precede the held entry.
- The held entry is never dropped except by flush or reset.
- busy_o = (state==BUBBLE). bub_left_o = counter in BUBBLE, 0 in IDLE.
- Latency: an accepted entry reaches valid_o DEPTH adv-cycles after acceptance (DEPTH=1: next edge). Cycles with stall_i=1 add 1 each.
- bub_req_i while valid_i=0 is ignored; no bubble sequence starts.
- valid_o/data_o are registered outputs with no combinational path from inputs.
- Reset asserted mid-bubble-sequence aborts it immediately (async).

Test Plan:
- Reset then stream: DEPTH=2, feed valid data 0x11,0x22,0x33 on consecutive cycles. Response: valid_o=1 with data_o 0x11,0x22,0x33 starting 2 cycles after the first accept; accept_o=1 every cycle.
- Bubble N=2: DEPTH=1, data 0xA0 with bub_req_i=1, bub_cnt_i=2. Response: accept_o=1 that cycle then 0 for 2 cycles; valid_o shows 0,0,then 1 with 0xA0; bub_left_o 1,0; busy_o high 2 cycles.
- Stall inside bubble: N=3, stall_i=1 for 2 cycles after the first bubble. Response: bub_left_o frozen at 2 during stall; valid_o and data_o held; total bubbles seen on valid_o still 3, then 0xA0.
- Flush mid-sequence: N=3, flush_i=1 on second BUBBLE cycle with stall_i=1 simultaneously. Response: next edge all valids 0, busy_o=0, bub_left_o=0; held 0xA0 never appears on valid_o.
- Zero count and reset: bub_req_i=1, bub_cnt_i=0 with data 0x55 loads normally (valid_o=1, 0x55 next cycle). Then assert rst_i asynchronously mid-cycle: valid_o=0, data_o=BUBBLE immediately, before the next clock edge.
